// File: rtl/pipe_stage_reg.sv
// Single-entry valid/ready pipeline register with bubble-safe control and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;
`else
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       stall_q, stall_d;
  logic              push, pop;

  assign out_valid   = (state_q != EMPTY);
  assign out_data    = data_q;
  assign out_rd_addr = rd_q;
  // Control is masked on a bubble so no write-back can fire from stale bits.
  assign out_ctrl    = out_valid ? ctrl_q : '0;
  assign stall_cnt   = stall_q;
  assign pop         = out_valid && out_ready;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [ADDR_W-1:0] srd_q, srd_d;
  logic [CTRL_W-1:0] sctrl_q, sctrl_d;
  logic              in_ready_q, in_ready_d;

  // in_ready comes only from a flop, breaking the out_ready -> in_ready path.
  assign in_ready = in_ready_q;
  assign push     = in_valid && in_ready_q && !flush;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    sdata_d    = sdata_q;
    srd_d      = srd_q;
    sctrl_d    = sctrl_q;
    if (flush) begin
      state_d = EMPTY;
      ctrl_d  = '0;
      sctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = FULL;
            data_d  = in_data;
            rd_d    = in_rd_addr;
            ctrl_d  = in_ctrl;
          end
        end
        FULL: begin
          if (push && pop) begin
            data_d = in_data;
            rd_d   = in_rd_addr;
            ctrl_d = in_ctrl;
          end else if (push) begin
            state_d = SKID;
            sdata_d = in_data;
            srd_d   = in_rd_addr;
            sctrl_d = in_ctrl;
          end else if (pop) begin
            state_d = EMPTY;
            ctrl_d  = '0;
          end
        end
        SKID: begin
          if (pop) begin
            state_d = FULL;
            data_d  = sdata_q;
            rd_d    = srd_q;
            ctrl_d  = sctrl_q;
            sctrl_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdata_q    <= '0;
      srd_q      <= '0;
      sctrl_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      sdata_q    <= sdata_d;
      srd_q      <= srd_d;
      sctrl_q    <= sctrl_d;
      in_ready_q <= in_ready_d;
    end
  end
`else
  assign in_ready = !reset && (!out_valid || out_ready);
  assign push     = in_valid && in_ready && !flush;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      state_d = EMPTY;
      ctrl_d  = '0;
    end else if (push) begin
      state_d = FULL;
      data_d  = in_data;
      rd_d    = in_rd_addr;
      ctrl_d  = in_ctrl;
    end else if (pop) begin
      state_d = EMPTY;
      ctrl_d  = '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg plus reset, skid and stall-saturation sequences.
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [4:0]  in_rd_addr, out_rd_addr;
  logic [1:0]  in_ctrl, out_ctrl;
  logic [15:0] stall_cnt;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .ADDR_W(5), .CTRL_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rd_addr(in_rd_addr), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd_addr(out_rd_addr), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        fl, iv;
    logic [63:0] d;
    logic [4:0]  rd;
    logic [1:0]  c;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [63:0] e_od;
    logic [4:0]  e_rd;
    logic [1:0]  e_oc;
    logic [15:0] e_st;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [63:0] d,
                       input logic [4:0] rd, input logic [1:0] c, input logic ordy);
    flush = fl; in_valid = iv; in_data = d; in_rd_addr = rd; in_ctrl = c; out_ready = ordy;
  endtask

  initial begin
    logic exp_ir;
    vecs[0]  = '{0, 0, 64'h0,  0, 0, 1, 1, 0, 64'h0,  0, 0, 16'd0};
    vecs[1]  = '{0, 1, 64'hA,  1, 1, 1, 1, 1, 64'hA,  1, 1, 16'd0};
    vecs[2]  = '{0, 1, 64'hB,  2, 2, 1, 1, 1, 64'hB,  2, 2, 16'd0};
    vecs[3]  = '{0, 1, 64'hC,  3, 3, 1, 1, 1, 64'hC,  3, 3, 16'd0};
    vecs[4]  = '{0, 0, 64'h0,  0, 0, 1, 1, 0, 64'hC,  3, 0, 16'd0};
    vecs[5]  = '{0, 1, 64'h55, 5, 1, 0, 1, 1, 64'h55, 5, 1, 16'd0};
    vecs[6]  = '{0, 0, 64'h0,  0, 0, 0, 0, 1, 64'h55, 5, 1, 16'd1};
    vecs[7]  = '{0, 0, 64'h0,  0, 0, 0, 0, 1, 64'h55, 5, 1, 16'd2};
    vecs[8]  = '{0, 0, 64'h0,  0, 0, 0, 0, 1, 64'h55, 5, 1, 16'd3};
    vecs[9]  = '{0, 0, 64'h0,  0, 0, 0, 0, 1, 64'h55, 5, 1, 16'd4};
    vecs[10] = '{0, 0, 64'h0,  0, 0, 0, 0, 1, 64'h55, 5, 1, 16'd5};
    vecs[11] = '{0, 1, 64'h66, 6, 2, 1, 1, 1, 64'h66, 6, 2, 16'd5};
    vecs[12] = '{0, 1, 64'h77, 7, 1, 1, 1, 1, 64'h77, 7, 1, 16'd5};
    vecs[13] = '{1, 1, 64'h88, 8, 3, 1, 1, 0, 64'h77, 7, 0, 16'd5};
    vecs[14] = '{0, 0, 64'h0,  0, 0, 0, 1, 0, 64'h77, 7, 0, 16'd5};
    vecs[15] = '{0, 1, 64'h99, 9, 2, 0, 1, 1, 64'h99, 9, 2, 16'd5};
    vecs[16] = '{1, 0, 64'h0,  0, 0, 0, 0, 0, 64'h99, 9, 0, 16'd6};
    vecs[17] = '{0, 0, 64'h0,  0, 0, 1, 1, 0, 64'h99, 9, 0, 16'd6};

    reset = 1'b1;
    drive(0, 0, 64'h0, 0, 0, 1);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].rd, vecs[i].c, vecs[i].ordy);
      #1;
`ifdef PIPE_STAGE_SKID_EN
      exp_ir = 1'b1;
`else
      exp_ir = vecs[i].e_ir;
`endif
      chk($sformatf("v%0d_in_ready", i), in_ready, exp_ir);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
      chk($sformatf("v%0d_out_rd", i), out_rd_addr, vecs[i].e_rd);
      chk($sformatf("v%0d_out_ctrl", i), out_ctrl, vecs[i].e_oc);
      chk($sformatf("v%0d_stall", i), stall_cnt, vecs[i].e_st);
    end

    // Reset asserted while an entry is held and stalled
    @(negedge clk); drive(0, 1, 64'h1234, 7, 2'b11, 0);
    @(posedge clk); #1;
    chk("mid_out_valid", out_valid, 1);
    chk("mid_out_ctrl", out_ctrl, 2'b11);
    @(negedge clk); drive(0, 0, 64'h0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_ctrl", out_ctrl, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_rd", out_rd_addr, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 0);

`ifdef PIPE_STAGE_SKID_EN
    @(negedge clk); drive(0, 1, 64'h1, 1, 1, 0);
    @(posedge clk); #1;
    chk("skid_first_data", out_data, 64'h1);
    @(negedge clk); drive(0, 1, 64'h2, 2, 2, 0);
    @(posedge clk); #1;
    chk("skid_in_ready_low", in_ready, 0);
    chk("skid_hold_data", out_data, 64'h1);
    chk("skid_hold_ctrl", out_ctrl, 1);
    @(negedge clk); drive(0, 0, 64'h0, 0, 0, 1);
    @(posedge clk); #1;
    chk("skid_drain_valid", out_valid, 1);
    chk("skid_drain_data", out_data, 64'h2);
    chk("skid_drain_ctrl", out_ctrl, 2);
    chk("skid_in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    chk("skid_empty_valid", out_valid, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk);
`endif

    // Stall counter saturation
    @(negedge clk); drive(0, 1, 64'hAB, 3, 1, 0);
    @(posedge clk);
    @(negedge clk); drive(0, 0, 64'h0, 0, 0, 0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall", stall_cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat_stall_hold", stall_cnt, 16'hFFFF);
    chk("sat_out_data", out_data, 64'hAB);
    chk("sat_out_valid", out_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
